regfile_write_arbiter: RTL and testbench
========================================

REGFILE_WRITE_ARBITER -- requirements
Module: regfile_write_arbiter

Interface
REQ-001 The block SHALL have parameter DATA_W, default 16, register data width.
REQ-002 The block SHALL have parameter ADDR_W, default 3, register address width (8 registers).
REQ-003 The block SHALL have port clk  input  1  the single clock; all state changes on its rising edge.
REQ-004 The block SHALL have port rst  input  1  asynchronous active-low reset.
REQ-005 The block SHALL have ports a_valid input 1, a_ready output 1, a_dest input ADDR_W, a_data input DATA_W; requester A (ALU writeback).
REQ-006 The block SHALL have ports b_valid input 1, b_ready output 1, b_dest input ADDR_W, b_data input DATA_W; requester B (load writeback).
REQ-007 The block SHALL have port hold  input  1  freeze; no grants while high.
REQ-008 The block SHALL have ports reg_write_en output 1, reg_write_dest output ADDR_W, reg_write_data output DATA_W; register-file write port.
REQ-009 The block SHALL have port busy  output 2**ADDR_W  one-hot pending-write flag per register.
REQ-010 The block SHALL have port wr_count  output 8  completed register-file writes, modulo 256.

Function
REQ-011 The block SHALL transfer a request only on the cycle where x_valid and x_ready are both high at the rising clk edge.
REQ-012 The block SHALL drive a_ready and b_ready combinationally from valids, hold and priority pointer, never both high in the same cycle.
REQ-013 The block SHALL drive both readies low while hold is high.
REQ-014 The block SHALL grant the sole valid requester when exactly one is valid and hold is low.
REQ-015 The block SHALL grant the requester named by priority pointer prio (0=A, 1=B) when both are valid and hold is low.
REQ-016 The block SHALL set prio to the non-granted requester after every grant, and leave prio unchanged on cycles with no grant.
REQ-017 Requesters SHALL keep valid, dest and data stable until handshake; the block SHALL NOT require this for correctness of arbitration.
REQ-018 The block SHALL register the granted dest and data and assert reg_write_en exactly one cycle after the handshake (latency 1).
REQ-019 The block SHALL sustain one write per cycle on back-to-back grants with no bubble.
REQ-020 The block SHALL deassert reg_write_en in any cycle not preceded by a handshake, holding reg_write_dest/reg_write_data at last values.
REQ-021 The block SHALL consume a request with dest 0 normally but SHALL drive reg_write_en low for it (register 0 is hardwired zero), and SHALL NOT count it.
REQ-022 The block SHALL assert busy[i] exactly while reg_write_en is high and reg_write_dest equals i; all other bits low.
REQ-023 The block SHALL increment wr_count by 1 on each cycle reg_write_en is high, wrapping 255 to 0.
REQ-024 When A and B target the same dest, the block SHALL issue the writes in grant order, later grant's data final.
REQ-025 Hold asserting on the cycle after a handshake SHALL NOT suppress the already-registered write.

Reset
REQ-026 On rst low the block SHALL immediately, without clk, drive reg_write_en 0, reg_write_dest 0, reg_write_data 0, busy 0, wr_count 0, prio 0, and both readies 0.
REQ-027 A handshake coinciding with the clock edge during which rst is low SHALL be discarded; no write issues after rst releases.
REQ-028 After rst returns high the block SHALL arbitrate from the first rising clk edge, A preferred.

Verification
REQ-029 Single: a_valid=1, a_dest=3, a_data=16'h1234 one cycle -> a_ready=1 that cycle; next cycle reg_write_en=1, dest=3, data=16'h1234, busy=8'b0000_1000, wr_count=1.
REQ-030 Contention: a and b valid continuously for 4 cycles from reset -> grants A,B,A,B; four writes on consecutive cycles; wr_count=4.
REQ-031 Zero dest: b_valid, b_dest=0, b_data=16'hFFFF -> b_ready=1; next cycle reg_write_en=0, busy=0, wr_count unchanged.
REQ-032 Hold: both valid, hold=1 for 3 cycles -> readies 0, no writes; hold drops -> grant to A (prio unchanged).
REQ-033 Reset mid-operation: rst low asynchronously while reg_write_en=1 -> all outputs 0 before next clk edge; wr_count 0 after release.
REQ-034 Wrap: 256 consecutive nonzero-dest writes -> wr_count returns to 0.

Source files
------------

// File: rtl/regfile_write_arbiter.sv
// rtl/regfile_write_arbiter.sv - two-requester register-file write arbiter
// Round-robin between ALU (A) and load (B) writeback, one registered write per cycle.
module regfile_write_arbiter #(
    parameter int DATA_W = 16,
    parameter int ADDR_W = 3
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  a_valid,
    output logic                  a_ready,
    input  logic [ADDR_W-1:0]     a_dest,
    input  logic [DATA_W-1:0]     a_data,
    input  logic                  b_valid,
    output logic                  b_ready,
    input  logic [ADDR_W-1:0]     b_dest,
    input  logic [DATA_W-1:0]     b_data,
    input  logic                  hold,
    output logic                  reg_write_en,
    output logic [ADDR_W-1:0]     reg_write_dest,
    output logic [DATA_W-1:0]     reg_write_data,
    output logic [2**ADDR_W-1:0]  busy,
    output logic [7:0]            wr_count
);

    logic              prio_q, prio_d;
    logic              en_q, en_d;
    logic [ADDR_W-1:0] dest_q, dest_d;
    logic [DATA_W-1:0] data_q, data_d;
    logic [7:0]        cnt_q, cnt_d;

    // Readies are gated by rst so they drop the instant reset asserts.
    always_comb begin
        a_ready = 1'b0;
        b_ready = 1'b0;
        if (rst && !hold) begin
            if (a_valid && (!b_valid || !prio_q)) begin
                a_ready = 1'b1;
            end else if (b_valid) begin
                b_ready = 1'b1;
            end
        end
    end

    always_comb begin
        prio_d = prio_q;
        en_d   = 1'b0;
        dest_d = dest_q;
        data_d = data_q;
        // Register 0 is hardwired zero: the request is consumed but never written.
        if (a_valid && a_ready) begin
            en_d   = (a_dest != '0);
            dest_d = a_dest;
            data_d = a_data;
            prio_d = 1'b1;
        end else if (b_valid && b_ready) begin
            en_d   = (b_dest != '0);
            dest_d = b_dest;
            data_d = b_data;
            prio_d = 1'b0;
        end
        cnt_d = cnt_q + 8'(en_d);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            prio_q <= 1'b0;
            en_q   <= 1'b0;
            dest_q <= '0;
            data_q <= '0;
            cnt_q  <= '0;
        end else begin
            prio_q <= prio_d;
            en_q   <= en_d;
            dest_q <= dest_d;
            data_q <= data_d;
            cnt_q  <= cnt_d;
        end
    end

    always_comb begin
        busy = '0;
        if (en_q) begin
            busy[dest_q] = 1'b1;
        end
    end

    assign reg_write_en   = en_q;
    assign reg_write_dest = dest_q;
    assign reg_write_data = data_q;
    assign wr_count       = cnt_q;

endmodule

// File: tb/tb_regfile_write_arbiter.sv
// tb/tb_regfile_write_arbiter.sv - randomized model-based bench for regfile_write_arbiter
module tb_regfile_write_arbiter;

    logic        clk = 1'b0;
    logic        rst;
    logic        a_valid, b_valid, hold;
    logic        a_ready, b_ready;
    logic [2:0]  a_dest, b_dest;
    logic [15:0] a_data, b_data;
    logic        reg_write_en;
    logic [2:0]  reg_write_dest;
    logic [15:0] reg_write_data;
    logic [7:0]  busy;
    logic [7:0]  wr_count;

    always #5 clk = ~clk;

    regfile_write_arbiter #(.DATA_W(16), .ADDR_W(3)) dut (
        .clk(clk), .rst(rst),
        .a_valid(a_valid), .a_ready(a_ready), .a_dest(a_dest), .a_data(a_data),
        .b_valid(b_valid), .b_ready(b_ready), .b_dest(b_dest), .b_data(b_data),
        .hold(hold),
        .reg_write_en(reg_write_en), .reg_write_dest(reg_write_dest),
        .reg_write_data(reg_write_data), .busy(busy), .wr_count(wr_count)
    );

    int n_chk  = 0;
    int n_fail = 0;

    logic        m_en;
    logic [2:0]  m_dest;
    logic [15:0] m_data;
    logic [7:0]  m_cnt;
    logic        m_prio;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_en = 1'b0; m_dest = '0; m_data = '0; m_cnt = '0; m_prio = 1'b0;
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_a_ready"}, 32'(a_ready), 0);
        chk({tag, "_b_ready"}, 32'(b_ready), 0);
        chk({tag, "_en"}, 32'(reg_write_en), 0);
        chk({tag, "_dest"}, 32'(reg_write_dest), 0);
        chk({tag, "_data"}, 32'(reg_write_data), 0);
        chk({tag, "_busy"}, 32'(busy), 0);
        chk({tag, "_count"}, 32'(wr_count), 0);
    endtask

    // One clock cycle: apply inputs, compare every output with the model, advance the model.
    task automatic cyc(input logic av, input logic [2:0] ad, input logic [15:0] adt,
                       input logic bv, input logic [2:0] bd, input logic [15:0] bdt,
                       input logic h, output logic ar, output logic br);
        logic ea, eb;
        a_valid = av; a_dest = ad; a_data = adt;
        b_valid = bv; b_dest = bd; b_data = bdt;
        hold = h;
        #2;
        ea = 1'b0; eb = 1'b0;
        if (!h) begin
            if (av && bv) begin
                if (m_prio) eb = 1'b1; else ea = 1'b1;
            end else if (av) ea = 1'b1;
            else if (bv) eb = 1'b1;
        end
        chk("a_ready", 32'(a_ready), 32'(ea));
        chk("b_ready", 32'(b_ready), 32'(eb));
        chk("reg_write_en", 32'(reg_write_en), 32'(m_en));
        chk("reg_write_dest", 32'(reg_write_dest), 32'(m_dest));
        chk("reg_write_data", 32'(reg_write_data), 32'(m_data));
        chk("busy", 32'(busy), m_en ? (32'd1 << m_dest) : 32'd0);
        chk("wr_count", 32'(wr_count), 32'(m_cnt));
        ar = a_ready; br = b_ready;
        if (ea) begin
            m_en = (ad != 0); m_dest = ad; m_data = adt; m_prio = 1'b1;
        end else if (eb) begin
            m_en = (bd != 0); m_dest = bd; m_data = bdt; m_prio = 1'b0;
        end else begin
            m_en = 1'b0;
        end
        if (m_en) m_cnt = m_cnt + 8'd1;
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b0;
        #1;
        model_reset();
        chk_all_zero("reset");
        @(posedge clk);
        #1;
        rst = 1'b1;
    endtask

    task automatic rand_cycles(input int n);
        logic ar, br;
        for (int i = 0; i < n; i++) begin
            cyc(($urandom_range(0, 9) < 6), 3'($urandom_range(0, 7)), 16'($urandom),
                ($urandom_range(0, 9) < 6), 3'($urandom_range(0, 7)), 16'($urandom),
                ($urandom_range(0, 9) < 2), ar, br);
        end
    endtask

    initial begin
        logic ar, br;
        rst = 1'b0;
        a_valid = 0; b_valid = 0; hold = 0;
        a_dest = 0; b_dest = 0; a_data = 0; b_data = 0;
        model_reset();
        @(posedge clk);
        #1;
        do_reset();

        // Single A write
        cyc(1, 3'd3, 16'h1234, 0, 3'd0, 16'h0, 0, ar, br);
        chk("single_a_ready", 32'(ar), 1);
        chk("single_b_ready", 32'(br), 0);
        chk("single_en", 32'(reg_write_en), 1);
        chk("single_dest", 32'(reg_write_dest), 3);
        chk("single_data", 32'(reg_write_data), 32'h1234);
        chk("single_busy", 32'(busy), 32'b0000_1000);
        chk("single_count", 32'(wr_count), 1);

        // Contention from reset: A,B,A,B back to back
        do_reset();
        for (int i = 0; i < 4; i++) begin
            cyc(1, 3'(i + 1), 16'(16'hA000 + i), 1, 3'(i + 4), 16'(16'hB000 + i), 0, ar, br);
            chk("cont_grant_a", 32'(ar), 32'((i % 2) == 0));
            chk("cont_grant_b", 32'(br), 32'((i % 2) == 1));
            chk("cont_en", 32'(reg_write_en), 1);
        end
        chk("cont_count", 32'(wr_count), 4);

        // Zero destination is consumed but not written
        cyc(0, 3'd0, 16'h0, 1, 3'd0, 16'hFFFF, 0, ar, br);
        chk("zero_b_ready", 32'(br), 1);
        chk("zero_en", 32'(reg_write_en), 0);
        chk("zero_busy", 32'(busy), 0);
        chk("zero_count", 32'(wr_count), 4);

        // Hold freezes grants; prio unchanged afterwards
        for (int i = 0; i < 3; i++) begin
            cyc(1, 3'd2, 16'hAAAA, 1, 3'd6, 16'hBBBB, 1, ar, br);
            chk("hold_a_ready", 32'(ar), 0);
            chk("hold_b_ready", 32'(br), 0);
        end
        chk("hold_no_write", 32'(reg_write_en), 0);
        cyc(1, 3'd2, 16'hAAAA, 1, 3'd6, 16'hBBBB, 0, ar, br);
        chk("hold_release_a", 32'(ar), 1);
        chk("hold_release_data", 32'(reg_write_data), 32'hAAAA);

        // Same destination from both: grant order B then A, A's data last
        cyc(1, 3'd5, 16'h1111, 1, 3'd5, 16'h2222, 0, ar, br);
        chk("same_first", 32'(reg_write_data), 32'h2222);
        cyc(1, 3'd5, 16'h1111, 0, 3'd0, 16'h0, 0, ar, br);
        chk("same_last", 32'(reg_write_data), 32'h1111);

        // Counter wrap after 256 writes
        do_reset();
        for (int i = 0; i < 256; i++) begin
            cyc(1, 3'($urandom_range(1, 7)), 16'($urandom), 0, 3'd0, 16'h0, 0, ar, br);
        end
        chk("wrap_count", 32'(wr_count), 0);
        chk("wrap_en", 32'(reg_write_en), 1);

        rand_cycles(2000);

        // Asynchronous reset while a write is on the port
        cyc(1, 3'd5, 16'h5555, 0, 3'd0, 16'h0, 0, ar, br);
        chk("async_pre_en", 32'(reg_write_en), 1);
        #2;
        a_valid = 1; b_valid = 1; hold = 0;
        rst = 1'b0;
        #1;
        chk_all_zero("async");
        @(posedge clk);
        #1;
        rst = 1'b1;
        #1;
        model_reset();
        chk("async_release_en", 32'(reg_write_en), 0);
        chk("async_release_count", 32'(wr_count), 0);
        cyc(1, 3'd1, 16'h0101, 1, 3'd2, 16'h0202, 0, ar, br);
        chk("post_reset_a_first", 32'(ar), 1);

        rand_cycles(1000);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
